pipe_hazard_sb: RTL

//  Scoreboard-based hazard and forwarding unit for the pipelined MIPS core, parametrised in depth.

---
 rtl/pipe_hazard_sb_pkg.sv | 21 ++
 rtl/pipe_fwd_match.sv | 41 ++++
 rtl/pipe_hazard_sb.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_sb_pkg.sv
// Shared defaults, widths and helpers for the ID-stage hazard/forwarding scoreboard.
package pipe_hazard_sb_pkg;

    localparam int unsigned NSTAGE_DEF   = 3;
    localparam int unsigned AW_DEF       = 5;
    localparam int unsigned DW_DEF       = 32;
    localparam int unsigned LOAD_RDY_DEF = 1;
    localparam int unsigned CNT_W        = 32;

    // Width of a forwarding select: 0 = regfile, k = entry k-1.
    function automatic int unsigned sel_w(input int unsigned nstage);
        return $clog2(nstage + 1);
    endfunction

    typedef enum logic [1:0] {
        HZ_NONE  = 2'd0,
        HZ_FLUSH = 2'd1,
        HZ_STALL = 2'd2
    } hz_action_e;

endpackage

// File: rtl/pipe_fwd_match.sv
// Per-operand scoreboard lookup: youngest matching in-flight write decides the
// forwarding select, or flags a load-use hazard when that write is a load not yet ready.
module pipe_fwd_match
    import pipe_hazard_sb_pkg::*;
#(
    parameter int unsigned NSTAGE   = NSTAGE_DEF,
    parameter int unsigned AW       = AW_DEF,
    parameter int unsigned LOAD_RDY = LOAD_RDY_DEF,
    parameter int unsigned SW       = sel_w(NSTAGE)
) (
    input  logic [AW-1:0]        i_src,
    input  logic                 i_used,
    input  logic [NSTAGE-1:0]    i_ent_valid,
    input  logic [NSTAGE-1:0]    i_ent_load,
    input  logic [NSTAGE*AW-1:0] i_ent_addr,
    output logic [SW-1:0]        o_sel,
    output logic                 o_luse
);

    logic w_src_live;

    assign w_src_live = i_used & (i_src != '0);

    // Walk oldest to youngest so the youngest match overrides.
    always_comb begin
        o_sel  = '0;
        o_luse = 1'b0;
        for (int k = int'(NSTAGE) - 1; k >= 0; k--) begin
            if (w_src_live && i_ent_valid[k] && (i_ent_addr[k*AW +: AW] == i_src)) begin
                if (i_ent_load[k] && (k < int'(LOAD_RDY))) begin
                    o_sel  = '0;
                    o_luse = 1'b1;
                end else begin
                    o_sel  = SW'(k + 1);
                    o_luse = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_sb.sv
// Hazard/forwarding scoreboard beside ID: tracks in-flight writes EX..WB and
// produces same-cycle operand forwarding, load-use/busy stalls and flush bubbles.
module pipe_hazard_sb
    import pipe_hazard_sb_pkg::*;
#(
    parameter int unsigned NSTAGE   = NSTAGE_DEF,
    parameter int unsigned AW       = AW_DEF,
    parameter int unsigned DW       = DW_DEF,
    parameter int unsigned LOAD_RDY = LOAD_RDY_DEF,
    localparam int unsigned SW      = sel_w(NSTAGE)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 id_valid,
    input  logic [AW-1:0]        id_rs,
    input  logic [AW-1:0]        id_rt,
    input  logic                 id_rs_used,
    input  logic                 id_rt_used,
    input  logic                 id_wr_en,
    input  logic [AW-1:0]        id_wr_addr,
    input  logic                 id_is_load,
    input  logic                 flush,
    input  logic                 ext_busy,
    input  logic [NSTAGE*DW-1:0] stage_data,
    input  logic [DW-1:0]        rf_rs_data,
    input  logic [DW-1:0]        rf_rt_data,
    output logic [SW-1:0]        fwd_rs_sel,
    output logic [SW-1:0]        fwd_rt_sel,
    output logic [DW-1:0]        fwd_rs_data,
    output logic [DW-1:0]        fwd_rt_data,
    output logic                 stall_pc,
    output logic                 stall_ifid,
    output logic                 bubble_ex,
    output logic [CNT_W-1:0]     luse_cnt
);

    logic [NSTAGE-1:0]    r_valid;
    logic [NSTAGE-1:0]    r_load;
    logic [NSTAGE*AW-1:0] r_addr;
    logic [CNT_W-1:0]     r_luse_cnt;

    logic [SW-1:0]        w_rs_sel;
    logic [SW-1:0]        w_rt_sel;
    logic                 w_rs_luse;
    logic                 w_rt_luse;
    logic                 w_luse;
    logic                 w_bubble;
    hz_action_e           w_action;

    pipe_fwd_match #(
        .NSTAGE   (NSTAGE),
        .AW       (AW),
        .LOAD_RDY (LOAD_RDY),
        .SW       (SW)
    ) u_match_rs (
        .i_src       (id_rs),
        .i_used      (id_rs_used),
        .i_ent_valid (r_valid),
        .i_ent_load  (r_load),
        .i_ent_addr  (r_addr),
        .o_sel       (w_rs_sel),
        .o_luse      (w_rs_luse)
    );

    pipe_fwd_match #(
        .NSTAGE   (NSTAGE),
        .AW       (AW),
        .LOAD_RDY (LOAD_RDY),
        .SW       (SW)
    ) u_match_rt (
        .i_src       (id_rt),
        .i_used      (id_rt_used),
        .i_ent_valid (r_valid),
        .i_ent_load  (r_load),
        .i_ent_addr  (r_addr),
        .o_sel       (w_rt_sel),
        .o_luse      (w_rt_luse)
    );

    assign w_luse = w_rs_luse | w_rt_luse;

    // Flush beats stall; while reset is low everything is forced quiet.
    always_comb begin
        w_action = HZ_NONE;
        if (!reset) begin
            w_action = HZ_NONE;
        end else if (flush) begin
            w_action = HZ_FLUSH;
        end else if (w_luse || ext_busy) begin
            w_action = HZ_STALL;
        end
    end

    always_comb begin
        stall_pc   = 1'b0;
        stall_ifid = 1'b0;
        w_bubble   = 1'b0;
        case (w_action)
            HZ_FLUSH: w_bubble = 1'b1;
            HZ_STALL: begin
                stall_pc   = 1'b1;
                stall_ifid = 1'b1;
                w_bubble   = 1'b1;
            end
            default: ;
        endcase
    end

    assign bubble_ex  = w_bubble;
    assign fwd_rs_sel = reset ? w_rs_sel : '0;
    assign fwd_rt_sel = reset ? w_rt_sel : '0;

    // Operand mux: select k picks the result of entry k-1.
    always_comb begin
        fwd_rs_data = rf_rs_data;
        fwd_rt_data = rf_rt_data;
        for (int unsigned k = 0; k < NSTAGE; k++) begin
            if (fwd_rs_sel == SW'(k + 1)) begin
                fwd_rs_data = stage_data[k*DW +: DW];
            end
            if (fwd_rt_sel == SW'(k + 1)) begin
                fwd_rt_data = stage_data[k*DW +: DW];
            end
        end
    end

    // In-flight write tracker; a bubbled ID instruction enters as invalid.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid <= '0;
            r_load  <= '0;
            r_addr  <= '0;
        end else begin
            r_valid[0]     <= id_valid & id_wr_en & ~w_bubble;
            r_load[0]      <= id_is_load;
            r_addr[0 +: AW] <= id_wr_addr;
            for (int unsigned k = 1; k < NSTAGE; k++) begin
                r_valid[k]         <= r_valid[k-1];
                r_load[k]          <= r_load[k-1];
                r_addr[k*AW +: AW] <= r_addr[(k-1)*AW +: AW];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_luse_cnt <= '0;
        end else if (w_luse && !flush && id_valid) begin
            r_luse_cnt <= r_luse_cnt + CNT_W'(1);
        end
    end

    assign luse_cnt = r_luse_cnt;

endmodule
